// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file write path.
package rf_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 32;

    typedef enum logic {INIT, RUN} state_t;

    // Power-on value of register k: k written as two BCD digits.
    function automatic logic [DATA_W-1:0] init_value(input logic [REG_ADDR_W-1:0] k);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = 4'(k / 5'd10);
        ones = 4'(k % 5'd10);
        return {{(DATA_W-8){1'b0}}, tens, ones};
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first valid requester at or above ptr, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [2:0]         ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [2:0]         idx,
    output logic               found
);
    logic [3:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int o = 0; o < NUM_REQ; o++) begin
            cand = {1'b0, ptr} + 4'(o);
            if (cand >= 4'(NUM_REQ))
                cand = cand - 4'(NUM_REQ);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && req[i] && cand == 4'(i)) begin
                    grant[i] = 1'b1;
                    idx      = 3'(i);
                    found    = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Owns the register-file write port: loads x1..x31 after reset, then
// round-robins writeback requesters onto the port with a 1-cycle latency.
module regfile_write_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int REG_ADDR_W = 5,
    parameter int DATA_W     = 32
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*REG_ADDR_W-1:0] req_reg,
    input  logic [NUM_REQ*DATA_W-1:0]     req_data,
    output logic [REG_ADDR_W-1:0]         write_reg,
    output logic [DATA_W-1:0]             write_data,
    output logic                          regwrite,
    output logic [2:0]                    grant_id,
    output logic                          init_done
);
    import rf_pkg::*;

    state_t                 state;
    logic [REG_ADDR_W-1:0]  cnt;
    logic [2:0]             ptr;
    logic [NUM_REQ-1:0]     grant;
    logic [2:0]             idx;
    logic                   found;
    logic                   run;
    logic [REG_ADDR_W-1:0]  sel_reg;
    logic [DATA_W-1:0]      sel_data;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (idx),
        .found (found)
    );

    // Reset gates ready so a requester never sees a handshake that reset will drop.
    assign run       = (state == RUN) && !reset;
    assign req_ready = run ? grant : '0;

    always_comb begin
        sel_reg  = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_reg  = req_reg[i*REG_ADDR_W +: REG_ADDR_W];
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= INIT;
            cnt        <= REG_ADDR_W'(1);
            ptr        <= '0;
            regwrite   <= 1'b0;
            write_reg  <= '0;
            write_data <= '0;
            grant_id   <= '0;
            init_done  <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    regwrite   <= 1'b1;
                    write_reg  <= cnt;
                    write_data <= DATA_W'(init_value(cnt));
                    cnt        <= cnt + 1'b1;
                    if (cnt == REG_ADDR_W'(NUM_REGS-1))
                        state <= RUN;
                end
                RUN: begin
                    init_done <= 1'b1;
                    if (found) begin
                        // x0 is hardwired zero: accept the transfer but keep the port quiet.
                        regwrite   <= (sel_reg != '0);
                        write_reg  <= sel_reg;
                        write_data <= sel_data;
                        grant_id   <= idx;
                        ptr        <= (idx == 3'(NUM_REQ-1)) ? 3'd0 : idx + 3'd1;
                    end else begin
                        regwrite <= 1'b0;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for the register-file write arbiter.
module tb_regfile_write_arbiter;
    localparam int N = 3;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N*5-1:0] req_reg = '0;
    logic [N*32-1:0] req_data = '0;
    logic [4:0]     write_reg;
    logic [31:0]    write_data;
    logic           regwrite;
    logic [2:0]     grant_id;
    logic           init_done;

    int checks = 0;
    int errors = 0;

    regfile_write_arbiter #(.NUM_REQ(N), .REG_ADDR_W(5), .DATA_W(32)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_reg    (req_reg),
        .req_data   (req_data),
        .write_reg  (write_reg),
        .write_data (write_data),
        .regwrite   (regwrite),
        .grant_id   (grant_id),
        .init_done  (init_done)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = '1;
        tick();
        tick();
        checks++; if (regwrite !== 1'b0) begin errors++; $display("FAIL rst_regwrite got=%0h exp=0", regwrite); end
        checks++; if (write_reg !== 5'd0) begin errors++; $display("FAIL rst_write_reg got=%0h exp=0", write_reg); end
        checks++; if (write_data !== 32'd0) begin errors++; $display("FAIL rst_write_data got=%0h exp=0", write_data); end
        checks++; if (grant_id !== 3'd0) begin errors++; $display("FAIL rst_grant_id got=%0h exp=0", grant_id); end
        checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL rst_init_done got=%0h exp=0", init_done); end
        checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL rst_req_ready got=%0b exp=000", req_ready); end
    endtask

    // Requesters stay valid during init to prove ready is held low.
    task automatic test_init();
        logic [31:0] exp;
        req_valid = '1;
        reset = 1'b0;
        for (int k = 1; k <= 31; k++) begin
            tick();
            if (k == 31) req_valid = '0;
            #1;
            exp = 32'((k / 10) * 16 + (k % 10));
            checks++; if (regwrite !== 1'b1) begin errors++; $display("FAIL init_regwrite k=%0d got=%0h exp=1", k, regwrite); end
            checks++; if (write_reg !== 5'(k)) begin errors++; $display("FAIL init_write_reg got=%0d exp=%0d", write_reg, k); end
            checks++; if (write_data !== exp) begin errors++; $display("FAIL init_write_data k=%0d got=%0h exp=%0h", k, write_data, exp); end
            checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL init_done_early k=%0d got=%0h exp=0", k, init_done); end
            checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL init_req_ready k=%0d got=%0b exp=000", k, req_ready); end
        end
        tick();
        checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL init_done_rise got=%0h exp=1", init_done); end
        checks++; if (regwrite !== 1'b0) begin errors++; $display("FAIL init_after_regwrite got=%0h exp=0", regwrite); end
    endtask

    task automatic test_back_to_back();
        int g;
        for (int i = 0; i < N; i++) begin
            req_reg[i*5 +: 5]   = 5'(10 + i);
            req_data[i*32 +: 32] = 32'hC0DE_0000 + 32'(i);
        end
        req_valid = '1;
        #1;
        for (int n = 0; n < 6; n++) begin
            g = n % 3;
            checks++; if (req_ready !== 3'(1 << g)) begin errors++; $display("FAIL b2b_ready n=%0d got=%0b exp=%0b", n, req_ready, 3'(1 << g)); end
            tick();
            checks++; if (regwrite !== 1'b1) begin errors++; $display("FAIL b2b_regwrite n=%0d got=%0h exp=1", n, regwrite); end
            checks++; if (grant_id !== 3'(g)) begin errors++; $display("FAIL b2b_grant_id n=%0d got=%0d exp=%0d", n, grant_id, g); end
            checks++; if (write_reg !== 5'(10 + g)) begin errors++; $display("FAIL b2b_write_reg n=%0d got=%0d exp=%0d", n, write_reg, 10 + g); end
            checks++; if (write_data !== 32'hC0DE_0000 + 32'(g)) begin errors++; $display("FAIL b2b_write_data n=%0d got=%0h exp=%0h", n, write_data, 32'hC0DE_0000 + 32'(g)); end
        end
        req_valid = '0;
        tick();
        checks++; if (regwrite !== 1'b0) begin errors++; $display("FAIL idle_regwrite got=%0h exp=0", regwrite); end
        checks++; if (write_reg !== 5'd12) begin errors++; $display("FAIL idle_hold_reg got=%0d exp=12", write_reg); end
        checks++; if (write_data !== 32'hC0DE_0002) begin errors++; $display("FAIL idle_hold_data got=%0h exp=c0de0002", write_data); end
    endtask

    task automatic test_x0();
        req_reg[0 +: 5]   = 5'd0;
        req_data[0 +: 32] = 32'h1234;
        req_valid = 3'b001;
        #1;
        checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL x0_ready got=%0b exp=001", req_ready); end
        tick();
        req_valid = '0;
        #1;
        checks++; if (regwrite !== 1'b0) begin errors++; $display("FAIL x0_regwrite got=%0h exp=0", regwrite); end
        checks++; if (grant_id !== 3'd0) begin errors++; $display("FAIL x0_grant_id got=%0d exp=0", grant_id); end
        // Pointer must now sit at 1: with 0 and 1 both valid, 1 wins.
        req_valid = 3'b011;
        #1;
        checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL x0_ptr_adv got=%0b exp=010", req_ready); end
        req_valid = '0;
    endtask

    task automatic test_pointer_skip();
        req_reg[0 +: 5]    = 5'd3;
        req_data[0 +: 32]  = 32'hAAAA_0000;
        req_reg[10 +: 5]   = 5'd7;
        req_data[64 +: 32] = 32'hBBBB_0002;
        req_valid = 3'b101;
        #1;
        checks++; if (req_ready !== 3'b100) begin errors++; $display("FAIL skip_ready1 got=%0b exp=100", req_ready); end
        tick();
        checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL skip_ready2 got=%0b exp=001", req_ready); end
        checks++; if (grant_id !== 3'd2) begin errors++; $display("FAIL skip_grant1 got=%0d exp=2", grant_id); end
        checks++; if (write_reg !== 5'd7 || write_data !== 32'hBBBB_0002) begin errors++; $display("FAIL skip_write1 got=%0d/%0h exp=7/bbbb0002", write_reg, write_data); end
        tick();
        req_valid = '0;
        #1;
        checks++; if (grant_id !== 3'd0) begin errors++; $display("FAIL skip_grant2 got=%0d exp=0", grant_id); end
        checks++; if (regwrite !== 1'b1 || write_reg !== 5'd3 || write_data !== 32'hAAAA_0000) begin errors++; $display("FAIL skip_write2 got=%0h/%0d/%0h exp=1/3/aaaa0000", regwrite, write_reg, write_data); end
    endtask

    task automatic test_single();
        req_reg[5 +: 5]    = 5'd5;
        req_data[32 +: 32] = 32'hDEADBEEF;
        req_valid = 3'b010;
        #1;
        checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL single_ready got=%0b exp=010", req_ready); end
        tick();
        req_valid = '0;
        #1;
        checks++; if (regwrite !== 1'b1) begin errors++; $display("FAIL single_regwrite got=%0h exp=1", regwrite); end
        checks++; if (write_reg !== 5'd5) begin errors++; $display("FAIL single_write_reg got=%0d exp=5", write_reg); end
        checks++; if (write_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_write_data got=%0h exp=deadbeef", write_data); end
        checks++; if (grant_id !== 3'd1) begin errors++; $display("FAIL single_grant_id got=%0d exp=1", grant_id); end
    endtask

    task automatic test_reset_mid();
        // A request in the reset cycle must not be granted or issued.
        req_valid = 3'b001;
        reset = 1'b1;
        #1;
        checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL rst_run_ready got=%0b exp=000", req_ready); end
        tick();
        req_valid = '0;
        checks++; if (regwrite !== 1'b0 || init_done !== 1'b0) begin errors++; $display("FAIL rst_run_out got=%0h/%0h exp=0/0", regwrite, init_done); end
        reset = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            checks++; if (write_reg !== 5'(k)) begin errors++; $display("FAIL mid_pre_reg got=%0d exp=%0d", write_reg, k); end
        end
        reset = 1'b1;
        tick();
        checks++; if (regwrite !== 1'b0) begin errors++; $display("FAIL mid_rst_regwrite got=%0h exp=0", regwrite); end
        checks++; if (write_reg !== 5'd0 || write_data !== 32'd0) begin errors++; $display("FAIL mid_rst_write got=%0d/%0h exp=0/0", write_reg, write_data); end
        checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL mid_rst_init_done got=%0h exp=0", init_done); end
        reset = 1'b0;
        for (int k = 1; k <= 31; k++) begin
            tick();
            checks++; if (regwrite !== 1'b1 || write_reg !== 5'(k)) begin errors++; $display("FAIL mid_restart got=%0h/%0d exp=1/%0d", regwrite, write_reg, k); end
            checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL mid_done_early k=%0d got=%0h exp=0", k, init_done); end
        end
        tick();
        checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL mid_done_rise got=%0h exp=1", init_done); end
    endtask

    initial begin
        test_reset();
        test_init();
        test_back_to_back();
        test_x0();
        test_pointer_skip();
        test_single();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
